// File: rtl/serial_pkg.sv
// Shared constants and helpers for the serial-controller FIFO bridge.
package serial_pkg;

  // Width of one serial byte.
  localparam int unsigned BYTE_W = 8;

  // Default log2 depth of each FIFO (16 entries).
  localparam int unsigned DEFAULT_DEPTH_LOG2 = 4;

  // Default RX occupancy at or above which the serial side is throttled.
  localparam int unsigned DEFAULT_STOP_LEVEL = 12;

  typedef logic [BYTE_W-1:0] byte_t;

  // A toggle handshake has a pending event when the local copy and the line differ.
  function automatic logic toggle_pending(input logic seen, input logic line);
    return seen ^ line;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// The head entry is always visible on rd_data while the FIFO is non-empty.
// A read and a write in the same cycle are both honoured at full: the read
// frees the slot the write lands in, so the count is unchanged.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   COUNT_ZERO = (DEPTH_LOG2 + 1)'(1'b0);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO   = (DEPTH_LOG2)'(1'b0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1'b1);

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  rd_ok_s;
  logic                  wr_ok_s;

  // Qualify strobes: reads need data, writes need space unless a read frees a slot.
  always_comb begin
    rd_ok_s = 1'b0;
    wr_ok_s = 1'b0;
    if (rd_en && (count_r != COUNT_ZERO)) begin
      rd_ok_s = 1'b1;
    end else begin
      rd_ok_s = 1'b0;
    end
    if (wr_en && ((count_r != COUNT_FULL) || rd_ok_s)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= COUNT_ZERO;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign empty   = (count_r == COUNT_ZERO);
  assign full    = (count_r == COUNT_FULL);
  assign count   = count_r;

endmodule

// File: rtl/serial_fifo_bridge.sv
// Bridges a toggle-handshake serial controller to two show-ahead byte FIFOs.
// RX: each ser_read_odd toggle delivers one byte into the RX FIFO; bytes that
// arrive while RX is full (and not being popped) are dropped and flagged.
// TX: whenever no request is outstanding, the TX head is issued by toggling
// ser_write_odd_request; the controller acknowledges by toggling ser_write_odd.
module serial_fifo_bridge
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int STOP_LEVEL = DEFAULT_STOP_LEVEL
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BYTE_W-1:0]   ser_data_read,
  input  logic                ser_read_odd,
  output logic                ser_try_stop_reading,
  output logic [BYTE_W-1:0]   ser_data_write,
  output logic                ser_write_odd_request,
  input  logic                ser_write_odd,
  output logic [BYTE_W-1:0]   rx_data,
  output logic                rx_valid,
  input  logic                rx_pop,
  input  logic [BYTE_W-1:0]   tx_data,
  input  logic                tx_push,
  output logic                tx_full,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic [DEPTH_LOG2:0] tx_count,
  output logic                rx_overflow,
  input  logic                ovf_clear
);

  localparam logic [DEPTH_LOG2:0] STOP_COUNT = STOP_LEVEL[DEPTH_LOG2:0];
  localparam byte_t               BYTE_ZERO  = 8'h00;

  // RX side
  logic                rx_seen_r;
  logic                rx_new_s;
  logic                rx_empty_s;
  logic                rx_full_s;
  logic                rx_pop_ok_s;
  logic                rx_drop_s;
  logic [DEPTH_LOG2:0] rx_count_s;
  byte_t               rx_head_s;
  logic                rx_overflow_r;
  logic                stop_r;

  // TX side
  logic                req_r;
  byte_t               data_write_r;
  logic                tx_idle_s;
  logic                tx_issue_s;
  logic                tx_empty_s;
  logic                tx_full_s;
  logic [DEPTH_LOG2:0] tx_count_s;
  byte_t               tx_head_s;

  sync_fifo #(
    .WIDTH      (BYTE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (rx_new_s),
    .wr_data (ser_data_read),
    .rd_en   (rx_pop),
    .rd_data (rx_head_s),
    .empty   (rx_empty_s),
    .full    (rx_full_s),
    .count   (rx_count_s)
  );

  sync_fifo #(
    .WIDTH      (BYTE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (tx_push),
    .wr_data (tx_data),
    .rd_en   (tx_issue_s),
    .rd_data (tx_head_s),
    .empty   (tx_empty_s),
    .full    (tx_full_s),
    .count   (tx_count_s)
  );

  // Detect new RX bytes and decide whether each one is kept or dropped.
  always_comb begin
    rx_new_s    = 1'b0;
    rx_pop_ok_s = 1'b0;
    rx_drop_s   = 1'b0;
    rx_new_s    = toggle_pending(rx_seen_r, ser_read_odd);
    if (rx_pop && !rx_empty_s) begin
      rx_pop_ok_s = 1'b1;
    end else begin
      rx_pop_ok_s = 1'b0;
    end
    if (rx_new_s && rx_full_s && !rx_pop_ok_s) begin
      rx_drop_s = 1'b1;
    end else begin
      rx_drop_s = 1'b0;
    end
  end

  // TX engine is idle when the request and acknowledge toggles agree.
  always_comb begin
    tx_idle_s  = 1'b0;
    tx_issue_s = 1'b0;
    tx_idle_s  = !toggle_pending(req_r, ser_write_odd);
    if (tx_idle_s && !tx_empty_s) begin
      tx_issue_s = 1'b1;
    end else begin
      tx_issue_s = 1'b0;
    end
  end

  // Track the last seen RX toggle; the controller's toggle is also cleared by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_seen_r <= ser_read_odd;
    end else begin
      rx_seen_r <= ser_read_odd;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_overflow_r <= 1'b0;
    end else if (rx_drop_s) begin
      rx_overflow_r <= 1'b1;
    end else if (ovf_clear) begin
      rx_overflow_r <= 1'b0;
    end else begin
      rx_overflow_r <= rx_overflow_r;
    end
  end

  // Registered flow control, following the RX occupancy by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stop_r <= 1'b0;
    end else begin
      stop_r <= (rx_count_s >= STOP_COUNT);
    end
  end

  // Issue the TX head: latch the byte and toggle the request in one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_r        <= ser_write_odd;
      data_write_r <= BYTE_ZERO;
    end else if (tx_issue_s) begin
      req_r        <= ~req_r;
      data_write_r <= tx_head_s;
    end else begin
      req_r        <= req_r;
      data_write_r <= data_write_r;
    end
  end

  assign ser_try_stop_reading  = stop_r;
  assign ser_data_write        = data_write_r;
  assign ser_write_odd_request = req_r;
  assign rx_data               = rx_head_s;
  assign rx_valid              = !rx_empty_s;
  assign rx_count              = rx_count_s;
  assign tx_count              = tx_count_s;
  assign tx_full               = tx_full_s;
  assign rx_overflow           = rx_overflow_r;

endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Self-checking bench for serial_fifo_bridge: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_serial_fifo_bridge;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int STOP  = 12;

  logic       clock;
  logic       reset;
  logic [7:0] ser_data_read;
  logic       ser_read_odd;
  logic       ser_try_stop_reading;
  logic [7:0] ser_data_write;
  logic       ser_write_odd_request;
  logic       ser_write_odd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_push;
  logic       tx_full;
  logic [DL:0] rx_count;
  logic [DL:0] tx_count;
  logic       rx_overflow;
  logic       ovf_clear;

  serial_fifo_bridge #(.DEPTH_LOG2(DL), .STOP_LEVEL(STOP)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .ser_data_read         (ser_data_read),
    .ser_read_odd          (ser_read_odd),
    .ser_try_stop_reading  (ser_try_stop_reading),
    .ser_data_write        (ser_data_write),
    .ser_write_odd_request (ser_write_odd_request),
    .ser_write_odd         (ser_write_odd),
    .rx_data               (rx_data),
    .rx_valid              (rx_valid),
    .rx_pop                (rx_pop),
    .tx_data               (tx_data),
    .tx_push               (tx_push),
    .tx_full               (tx_full),
    .rx_count              (rx_count),
    .tx_count              (tx_count),
    .rx_overflow           (rx_overflow),
    .ovf_clear             (ovf_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  logic       m_seen, m_req, m_ovf, m_stop;
  logic [7:0] m_dw;
  int         m_rxn, m_txn;
  bit         m_pop_ok, m_new, m_drop, m_issue;

  always @(posedge clock) begin
    if (reset) begin
      m_rx.delete();
      m_tx.delete();
      m_seen = ser_read_odd;
      m_req  = ser_write_odd;
      m_ovf  = 1'b0;
      m_stop = 1'b0;
      m_dw   = 8'h00;
    end else begin
      m_rxn    = m_rx.size();
      m_txn    = m_tx.size();
      m_pop_ok = rx_pop && (m_rxn > 0);
      m_new    = (ser_read_odd != m_seen);
      m_drop   = m_new && (m_rxn == DEPTH) && !m_pop_ok;
      m_stop   = (m_rxn >= STOP);
      if (m_pop_ok) void'(m_rx.pop_front());
      if (m_new && !m_drop) m_rx.push_back(ser_data_read);
      m_seen = ser_read_odd;
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clear) m_ovf = 1'b0;
      m_issue = (m_req == ser_write_odd) && (m_txn > 0);
      if (m_issue) begin
        m_dw  = m_tx.pop_front();
        m_req = ~m_req;
      end
      if (tx_push && ((m_txn < DEPTH) || m_issue)) m_tx.push_back(tx_data);
    end
    #1;
    if (!reset) begin
      chk("rx_valid", rx_valid, (m_rx.size() > 0));
      if (m_rx.size() > 0) chk("rx_data", rx_data, m_rx[0]);
      chk("rx_count", rx_count, m_rx.size());
      chk("tx_count", tx_count, m_tx.size());
      chk("tx_full", tx_full, (m_tx.size() == DEPTH));
      chk("rx_overflow", rx_overflow, m_ovf);
      chk("stop", ser_try_stop_reading, m_stop);
      chk("req", ser_write_odd_request, m_req);
      chk("data_write", ser_data_write, m_dw);
    end
  end

  // ---------------- controller emulation / stimulus ----------------
  bit         ctl_auto;
  int         ctl_delay;
  int         wait_cnt;
  int         req_toggles;
  logic       prev_req;
  logic [7:0] latched[$];

  task automatic tick();
    if (ctl_auto && (ser_write_odd_request != ser_write_odd)) begin
      wait_cnt++;
      if (wait_cnt >= ctl_delay) begin
        latched.push_back(ser_data_write);
        ser_write_odd = ~ser_write_odd;
        wait_cnt = 0;
      end
    end
    if (ser_write_odd_request != prev_req) req_toggles++;
    prev_req = ser_write_odd_request;
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    ser_data_read = b;
    ser_read_odd  = ~ser_read_odd;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ser_read_odd = 1'b0;
    ser_write_odd = 1'b0;
    rx_pop = 1'b0;
    tx_push = 1'b0;
    ovf_clear = 1'b0;
    wait_cnt = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    prev_req = ser_write_odd_request;
    req_toggles = 0;
    latched.delete();
  endtask

  initial begin
    reset = 1'b1;
    ser_data_read = 8'h00;
    ser_read_odd = 1'b0;
    ser_write_odd = 1'b0;
    rx_pop = 1'b0;
    tx_data = 8'h00;
    tx_push = 1'b0;
    ovf_clear = 1'b0;
    ctl_auto = 1'b0;
    ctl_delay = 3;
    prev_req = 1'b0;
    do_reset();

    // reset state
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_data_write", ser_data_write, 8'h00);

    // single byte in, then pop
    send_byte(8'h41);
    chk("rx1_valid", rx_valid, 1'b1);
    chk("rx1_data", rx_data, 8'h41);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    chk("rx1_pop_valid", rx_valid, 1'b0);

    // flow control threshold
    for (int i = 0; i < 12; i++) send_byte(8'h20 + 8'(i));
    chk("stop_lag", ser_try_stop_reading, 1'b0);
    tick();
    chk("stop_on", ser_try_stop_reading, 1'b1);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    chk("stop_pop_cnt", rx_count, 5'd11);
    chk("stop_hold", ser_try_stop_reading, 1'b1);
    tick();
    chk("stop_off", ser_try_stop_reading, 1'b0);

    // overflow
    do_reset();
    for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
    chk("ovf_set", rx_overflow, 1'b1);
    chk("ovf_count", rx_count, 5'd16);
    chk("ovf_head", rx_data, 8'h10);
    ovf_clear = 1'b1;
    send_byte(8'hEE);
    chk("ovf_set_wins", rx_overflow, 1'b1);
    tick();
    ovf_clear = 1'b0;
    chk("ovf_cleared", rx_overflow, 1'b0);

    // TX two bytes through the controller
    do_reset();
    ctl_auto = 1'b1;
    ctl_delay = 3;
    tx_data = 8'h55; tx_push = 1'b1;
    tick();
    tx_data = 8'hAA;
    tick();
    tx_push = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("tx2_toggles", req_toggles, 2);
    chk("tx2_latched_n", latched.size(), 2);
    if (latched.size() == 2) begin
      chk("tx2_first", latched[0], 8'h55);
      chk("tx2_second", latched[1], 8'hAA);
    end
    chk("tx2_count", tx_count, 5'd0);

    // TX full with stalled controller
    ctl_auto = 1'b0;
    do_reset();
    for (int k = 0; k < 20 && !tx_full; k++) begin
      tx_data = 8'(k); tx_push = 1'b1;
      tick();
    end
    tx_push = 1'b0;
    chk("txf_full", tx_full, 1'b1);
    chk("txf_count", tx_count, 5'd16);
    tx_data = 8'h99; tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
    chk("txf_ignored", tx_count, 5'd16);
    ser_write_odd = ~ser_write_odd;
    tx_data = 8'h77; tx_push = 1'b1;
    tick();
    tx_push = 1'b0;
    chk("txf_poppush", tx_count, 5'd16);
    chk("txf_data", ser_data_write, 8'h01);

    // reset mid-transfer
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'h70 + 8'(i); tx_push = 1'b1;
      tick();
    end
    tx_push = 1'b0;
    chk("mid_rx", rx_count, 5'd5);
    chk("mid_tx", tx_count, 5'd3);
    reset = 1'b1;
    ser_read_odd = 1'b0;
    ser_write_odd = 1'b0;
    #1;
    chk("async_rx", rx_count, 5'd0);
    chk("async_tx", tx_count, 5'd0);
    chk("async_req", ser_write_odd_request, 1'b0);
    do_reset();
    ctl_auto = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("post_rst_toggles", req_toggles, 0);
    chk("post_rst_valid", rx_valid, 1'b0);
    chk("post_rst_ovf", rx_overflow, 1'b0);

    // randomized traffic
    do_reset();
    ctl_auto = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int pop_pct, push_pct;
      pop_pct  = (i < 1000) ? 15 : ((i < 2000) ? 75 : 45);
      push_pct = (i < 1000) ? 80 : ((i < 2000) ? 20 : 50);
      ctl_delay = $urandom_range(1, 5);
      if ($urandom_range(0, 99) < 55) begin
        ser_data_read = 8'($urandom);
        ser_read_odd  = ~ser_read_odd;
      end
      rx_pop    = ($urandom_range(0, 99) < pop_pct);
      tx_push   = ($urandom_range(0, 99) < push_pct);
      tx_data   = 8'($urandom);
      ovf_clear = ($urandom_range(0, 99) < 4);
      tick();
    end
    rx_pop = 1'b0;
    tx_push = 1'b0;
    ovf_clear = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
